mdr_mem_interface: RTL and testbench

Memory Data Register (MDR) stage between the internal 32-bit CPU bus and external memory.
- Loads from the bus or from memory; drives the stored word back onto the bus through a tri-state output.
- Runs a request/ready handshake FSM for memory reads and writes.
- Sits beside the general registers on the BusMuxOut/BusMuxIn bus; the control unit sequences it with MDRin/MDRout/Read/Write and waits on Done.

---
 rtl/mdr_mem_interface.sv | 185 ++++++++++++++++++
 tb/tb_mdr_mem_interface.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_interface.sv
// Memory Data Register between the 32-bit CPU bus and external memory.
// Optional wait-state timeout is built when MDR_TIMEOUT_EN is defined.
module mdr_mem_interface #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MDRin,
    input  logic                  MDRout,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] MemDataIn,
    input  logic                  MemReady,
    output logic [DATA_WIDTH-1:0] BusMuxIn,
    output logic [DATA_WIDTH-1:0] MemDataOut,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  Busy,
    output logic                  Done,
    output logic                  BusError
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] mdr_d;

    logic waiting;
    logic timeout;

    logic memread_d;
    logic memwrite_d;
    logic busy_d;
    logic done_d;

    assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef MDR_TIMEOUT_EN
    localparam int CW = 10;

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // Wait counter: cleared in IDLE (every wait is entered from IDLE)
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (waiting && !MemReady) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A ready memory wins over a timeout landing on the same edge
    assign timeout = waiting && !MemReady &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, cleared when a new access is accepted
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && (Read || Write)) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign BusError = err_q;
`else
    wire [9:0] unused_tmo = 10'(TIMEOUT_CYCLES);

    assign timeout  = 1'b0;
    assign BusError = 1'b0;
`endif

    // State register
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; Read beats Write when both arrive in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (Read) begin
                    state_nxt = RD_WAIT;
                end else if (Write) begin
                    state_nxt = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (MemReady || timeout) begin
                    state_nxt = DONE;
                end
            end
            WR_WAIT: begin
                if (MemReady || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        memread_d  = (state_nxt == RD_WAIT);
        memwrite_d = (state_nxt == WR_WAIT);
        busy_d     = memread_d || memwrite_d;
        done_d     = (state_nxt == DONE);
    end

    // Registered handshake outputs
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            MemRead  <= memread_d;
            MemWrite <= memwrite_d;
            Busy     <= busy_d;
            Done     <= done_d;
        end
    end

    // Stored word: bus loads only outside waits; read data on completion
    always_comb begin
        mdr_d = mdr_q;
        unique case (state)
            IDLE, DONE: begin
                if (MDRin) begin
                    mdr_d = BusMuxOut;
                end
            end
            RD_WAIT: begin
                if (MemReady) begin
                    mdr_d = MemDataIn;
                end
            end
            WR_WAIT: begin
                mdr_d = mdr_q;
            end
            default: begin
                mdr_d = mdr_q;
            end
        endcase
    end

    // Stored word register
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            mdr_q <= '0;
        end else begin
            mdr_q <= mdr_d;
        end
    end

    assign MemDataOut = mdr_q;
    assign BusMuxIn   = MDRout ? mdr_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Scoreboard bench for mdr_mem_interface.
// Random load/read/write traffic checked against a word-level model.
module tb_mdr_mem_interface;

    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Clear = 1'b0;
    logic [W-1:0] BusMuxOut = '0;
    logic         MDRin = 1'b0;
    logic         MDRout = 1'b0;
    logic         Read = 1'b0;
    logic         Write = 1'b0;
    logic [W-1:0] MemDataIn = '0;
    logic         MemReady = 1'b0;
    wire  [W-1:0] BusMuxIn;
    logic [W-1:0] MemDataOut;
    logic         MemRead;
    logic         MemWrite;
    logic         Busy;
    logic         Done;
    logic         BusError;

    mdr_mem_interface #(
        .DATA_WIDTH    (W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .BusMuxOut (BusMuxOut),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .Read      (Read),
        .Write     (Write),
        .MemDataIn (MemDataIn),
        .MemReady  (MemReady),
        .BusMuxIn  (BusMuxIn),
        .MemDataOut(MemDataOut),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Busy      (Busy),
        .Done      (Done),
        .BusError  (BusError)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: the word the register should hold
    logic [W-1:0] model_word = '0;
    logic [W-1:0] zval;

    typedef struct {
        int           rd;
        int           wr;
        logic [W-1:0] word;
        logic         err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string n, input logic [W-1:0] a,
                       input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    // Monitor: counts request cycles and checks each Done against the queue
    int           rd_n = 0;
    int           wr_n = 0;
    logic [W-1:0] wr_val = '0;
    bit           wr_unstable = 0;
    bit           after_done = 0;
    exp_t         got;

    always @(negedge Clock or negedge Clear) begin
        if (!Clear) begin
            rd_n        = 0;
            wr_n        = 0;
            wr_unstable = 0;
            after_done  = 0;
        end else begin
            chk("rd_wr_exclusive", W'(MemRead & MemWrite), '0);
            chk("busy", W'(Busy), W'(MemRead | MemWrite));
            if (MemRead) rd_n++;
            if (MemWrite) begin
                if (wr_n == 0) wr_val = MemDataOut;
                else if (MemDataOut !== wr_val) wr_unstable = 1;
                wr_n++;
            end
            if (after_done) begin
                chk("done_one_cycle", W'(Done), '0);
                after_done = 0;
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", W'(Done), '0);
                end else begin
                    got = sb.pop_front();
                    chk("rd_cycles", W'(rd_n), W'(got.rd));
                    chk("wr_cycles", W'(wr_n), W'(got.wr));
                    chk("word_at_done", MemDataOut, got.word);
                    chk("buserror_at_done", W'(BusError), W'(got.err));
                    chk("wr_data_stable", W'(wr_unstable), '0);
                end
                rd_n        = 0;
                wr_n        = 0;
                wr_unstable = 0;
                after_done  = 1;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic probe();
        MDRout = 1'b1;
        #1;
        chk("busmuxin_drive", BusMuxIn, model_word);
        MDRout = 1'b0;
        #1;
        chk("busmuxin_z", BusMuxIn, zval);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        MDRin     = 1'b1;
        BusMuxOut = v;
        tick();
        MDRin      = 1'b0;
        model_word = v;
    endtask

    // The DONE cycle: stray requests must be ignored, a bus load is honoured
    task automatic done_cycle(input bit rq, input bit ld);
        logic [W-1:0] v;
        v     = $urandom;
        Read  = rq;
        Write = rq ? 1'($urandom) : 1'b0;
        if (ld) begin
            MDRin      = 1'b1;
            BusMuxOut  = v;
            model_word = v;
        end
        tick();
        Read  = 1'b0;
        Write = 1'b0;
        MDRin = 1'b0;
    endtask

    task automatic do_read(input logic [W-1:0] data, input int waits,
                           input bit both, input bit rq, input bit ld);
        exp_t e;
        e.rd   = waits + 1;
        e.wr   = 0;
        e.word = data;
        e.err  = 1'b0;
        sb.push_back(e);
        Read      = 1'b1;
        Write     = both;
        MDRin     = 1'($urandom);
        BusMuxOut = $urandom;
        tick();
        Read      = 1'b0;
        Write     = 1'b0;
        MDRin     = 1'b1;
        BusMuxOut = 32'h1111_1111;
        MemDataIn = $urandom;
        repeat (waits) begin
            tick();
            MemDataIn = $urandom;
        end
        MemReady  = 1'b1;
        MemDataIn = data;
        tick();
        MemReady   = 1'b0;
        MDRin      = 1'b0;
        model_word = data;
        done_cycle(rq, ld);
    endtask

    task automatic do_write(input int waits, input bit rq, input bit ld);
        exp_t e;
        e.rd   = 0;
        e.wr   = waits + 1;
        e.word = model_word;
        e.err  = 1'b0;
        sb.push_back(e);
        Write = 1'b1;
        tick();
        Write     = 1'b0;
        MDRin     = 1'b1;
        BusMuxOut = $urandom;
        repeat (waits) tick();
        MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        MDRin    = 1'b0;
        done_cycle(rq, ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zval = {W{1'bz}};
        #12;
        chk("rst_memread", W'(MemRead), '0);
        chk("rst_memwrite", W'(MemWrite), '0);
        chk("rst_busy", W'(Busy), '0);
        chk("rst_done", W'(Done), '0);
        chk("rst_buserror", W'(BusError), '0);
        chk("rst_memdataout", MemDataOut, '0);
        probe();
        Clear = 1'b1;
        tick();

        // Directed: load then write with three wait states
        do_load(32'hA5A5_1234);
        probe();
        do_write(3, 1'b0, 1'b0);
        // Directed: read ready in the first wait cycle
        do_read(32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b0);
        probe();
        // Directed: Read+Write together, MDRin during the wait
        do_read(32'h0BAD_F00D, 2, 1'b1, 1'b1, 1'b0);
        probe();

        // Asynchronous reset in the middle of a write wait
        do_load(32'h5555_AAAA);
        Write = 1'b1;
        tick();
        Write = 1'b0;
        tick();
        chk("wr_wait_memwrite", W'(MemWrite), 1);
        #1;
        Clear = 1'b0;
        #1;
        chk("arst_memwrite", W'(MemWrite), '0);
        chk("arst_busy", W'(Busy), '0);
        chk("arst_word", MemDataOut, '0);
        chk("arst_done", W'(Done), '0);
        Clear      = 1'b1;
        model_word = '0;
        probe();
        do_write(0, 1'b0, 1'b0);

`ifdef MDR_TIMEOUT_EN
        begin
            exp_t e;
            do_load(32'hCAFE_0001);
            e.rd   = 4;
            e.wr   = 0;
            e.word = model_word;
            e.err  = 1'b1;
            sb.push_back(e);
            Read = 1'b1;
            tick();
            Read = 1'b0;
            repeat (4) tick();
            tick();
            repeat (3) tick();
            chk("buserror_sticky", W'(BusError), 1);
            probe();
            do_read(32'h1234_5678, 1, 1'b0, 1'b0, 1'b0);
            chk("buserror_cleared", W'(BusError), '0);
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                do_load($urandom);
            end else if (op == 1) begin
                do_read($urandom, int'($urandom_range(0, 2)),
                        1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                do_write(int'($urandom_range(0, 2)),
                         1'($urandom), 1'($urandom));
            end
            probe();
        end

        repeat (3) tick();
        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
